// File: rtl/lfsr_step_scheduler_pkg.sv
// Shared constants and types for the LFSR step scheduler.
package lfsr_step_scheduler_pkg;

  localparam int unsigned PERIOD_W = 32;
  localparam int unsigned NUM_BTN  = 5;

  // Button bit positions on the board button vector
  localparam int unsigned BTN_FAST0  = 0;
  localparam int unsigned BTN_SLOW0  = 1;
  localparam int unsigned BTN_SLOW1  = 2;
  localparam int unsigned BTN_FAST1  = 3;
  localparam int unsigned BTN_CENTRE = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

endpackage

// File: rtl/button_debouncer.sv
// Per-bit 2-flop synchroniser followed by a stable-level debouncer.
module button_debouncer #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] btn_o
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            db_q, db_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Synchronise the raw asynchronous buttons into clk
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Flip a debounced bit once the synchronised level has differed for DEBOUNCE_CYCLES cycles
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounced level and stability counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q  <= '0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign btn_o = db_q;

endmodule

// File: rtl/lfsr_step_scheduler.sv
// Step-enable scheduler for the LFSR datapath: button-controlled rate, pause,
// single-step and resume. Optional build macro LFSR_STOP_ON_WRAP_EN auto-pauses
// after the step taken while max_tick is high.
module lfsr_step_scheduler
  import lfsr_step_scheduler_pkg::*;
#(
  parameter int unsigned PERIOD_DEFAULT  = 5_000_000,
  parameter int unsigned PERIOD_MIN      = 39_062,
  parameter int unsigned PERIOD_MAX      = 80_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTN-1:0]  button_input,
  input  logic                max_tick,
  output logic                step_en,
  output logic [PERIOD_W-1:0] period,
  output logic [1:0]          mode,
  output logic                running
);

  localparam logic [1:0] S_RUN    = 2'(ST_RUN);
  localparam logic [1:0] S_PAUSED = 2'(ST_PAUSED);
  localparam logic [1:0] S_STEP   = 2'(ST_STEP);

  localparam logic [PERIOD_W-1:0] P_DEF = PERIOD_W'(PERIOD_DEFAULT);
  localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(PERIOD_MIN);
  localparam logic [PERIOD_W-1:0] P_MAX = PERIOD_W'(PERIOD_MAX);

  logic [NUM_BTN-1:0]  db, db_prev_q, rise;
  logic                lock_q, lock_d;
  logic                evt_valid, evt_fast, evt_slow, evt_centre;
  logic [1:0]          state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                step_en_q, step_en_d;
  logic                running_q, running_d;
  logic [PERIOD_W-1:0] period_half, period_fast;
  logic [PERIOD_W:0]   period_dbl;
  logic [PERIOD_W-1:0] period_slow;

  button_debouncer #(
    .WIDTH           (NUM_BTN),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_i  (clk),
    .rst_ni (reset),
    .btn_i  (button_input),
    .btn_o  (db)
  );

  // Press decode: one prioritised event per press while the lock is clear
  always_comb begin
    rise       = db & ~db_prev_q;
    evt_valid  = !lock_q && (rise != '0);
    evt_fast   = evt_valid && (rise[BTN_FAST0] || rise[BTN_FAST1]);
    evt_slow   = evt_valid && !evt_fast && (rise[BTN_SLOW0] || rise[BTN_SLOW1]);
    evt_centre = evt_valid && !evt_fast && !evt_slow && rise[BTN_CENTRE];
  end

  // Clamped halved/doubled periods; the doubled value keeps a carry bit
  always_comb begin
    period_half = period_q >> 1;
    period_fast = (period_half < P_MIN) ? P_MIN : period_half;
    period_dbl  = {1'b0, period_q} << 1;
    period_slow = (period_dbl > {1'b0, P_MAX}) ? P_MAX : period_dbl[PERIOD_W-1:0];
  end

  // Next-state logic for the mode FSM, period, step counter and press lock
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    step_en_d = 1'b0;
    lock_d    = lock_q;

    if (db == '0) lock_d = 1'b0;
    if (evt_valid) lock_d = 1'b1;

    case (state_q)
      S_RUN: begin
        if (cnt_q == period_q - PERIOD_W'(1)) begin
          cnt_d     = '0;
          step_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
        if (evt_fast) begin
          period_d  = period_fast;
          cnt_d     = '0;
          step_en_d = 1'b0;
        end else if (evt_slow) begin
          period_d  = period_slow;
          cnt_d     = '0;
          step_en_d = 1'b0;
        end else if (evt_centre) begin
          state_d   = S_PAUSED;
          cnt_d     = '0;
          step_en_d = 1'b0;
        end
      end
      S_PAUSED: begin
        cnt_d = '0;
        if (evt_fast) begin
          state_d   = S_STEP;
          step_en_d = 1'b1;
        end else if (evt_slow) begin
          period_d = P_DEF;
        end else if (evt_centre) begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        cnt_d   = '0;
        state_d = S_PAUSED;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
    endcase

`ifdef LFSR_STOP_ON_WRAP_EN
    // The step taken on the final sequence state parks the scheduler
    if (step_en_q && max_tick && (state_q == S_RUN || state_q == S_STEP)) begin
      state_d   = S_PAUSED;
      cnt_d     = '0;
      step_en_d = 1'b0;
    end
`endif

    running_d = (state_d == S_RUN);
  end

`ifndef LFSR_STOP_ON_WRAP_EN
  logic unused_max_tick;
  assign unused_max_tick = max_tick;
`endif

  // Scheduler state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      period_q  <= P_DEF;
      cnt_q     <= '0;
      step_en_q <= 1'b0;
      running_q <= 1'b1;
      lock_q    <= 1'b0;
      db_prev_q <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      step_en_q <= step_en_d;
      running_q <= running_d;
      lock_q    <= lock_d;
      db_prev_q <= db;
    end
  end

  assign step_en = step_en_q;
  assign period  = period_q;
  assign mode    = state_q;
  assign running = running_q;

endmodule

// File: tb/tb_lfsr_step_scheduler.sv
// Self-checking bench for lfsr_step_scheduler (small periods, short debounce).
module tb_lfsr_step_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  btn;
  logic        max_tick;
  logic        step_en;
  logic [31:0] period;
  logic [1:0]  mode;
  logic        running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int got_q[$];

  typedef struct {
    logic [4:0]  btn;
    logic [31:0] exp_period;
    logic [1:0]  exp_mode;
    int          spacing;
    int          len;
  } vec_t;

  vec_t vecs[8];

  lfsr_step_scheduler #(
    .PERIOD_DEFAULT  (8),
    .PERIOD_MIN      (2),
    .PERIOD_MAX      (32),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_input (btn),
    .max_tick     (max_tick),
    .step_en      (step_en),
    .period       (period),
    .mode         (mode),
    .running      (running)
  );

  always #5 clk = ~clk;

  // Cycle counter and step_en pulse log, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (step_en === 1'b1) got_q.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Press (OR into the held set); returns at the cycle the action should land
  task automatic press(input logic [4:0] mask);
    int k;
    k = cyc;
    btn = btn | mask;
    while (cyc < k + 7) @(negedge clk);
  endtask

  task automatic release_all();
    btn = '0;
    repeat (8) @(negedge clk);
  endtask

  // Expect pulses at ref+spacing, ref+2*spacing, ... up to ref+len
  task automatic pulse_window(input string name, input int ref_cyc, input int spacing, input int len);
    int exp_q[$];
    int n;
    got_q.delete();
    if (spacing > 0)
      for (int t = ref_cyc + spacing; t <= ref_cyc + len; t += spacing) exp_q.push_back(t);
    while (cyc < ref_cyc + len) @(negedge clk);
    chk({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, " at"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
  endtask

  task automatic wait_step(input string name);
    int n = 0;
    while (step_en !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " step seen"}, 32'(step_en), 32'd1);
  endtask

  initial begin
    int u;
    int r;

    vecs[0] = '{5'b00001, 32'd4,  2'd0, 0,  0};
    vecs[1] = '{5'b01000, 32'd2,  2'd0, 0,  0};
    vecs[2] = '{5'b00001, 32'd2,  2'd0, 2,  12};
    vecs[3] = '{5'b00010, 32'd4,  2'd0, 0,  0};
    vecs[4] = '{5'b00100, 32'd8,  2'd0, 0,  0};
    vecs[5] = '{5'b00010, 32'd16, 2'd0, 0,  0};
    vecs[6] = '{5'b00100, 32'd32, 2'd0, 32, 70};
    vecs[7] = '{5'b00010, 32'd32, 2'd0, 0,  0};

    reset = 1'b0;
    btn = '0;
    max_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset step_en", 32'(step_en), 32'd0);
    chk("reset mode",    32'(mode),    32'd0);
    chk("reset period",  period,       32'd8);
    chk("reset running", 32'(running), 32'd1);

    reset = 1'b1;
    r = cyc;
    pulse_window("default pulses", r, 8, 40);

    // Rate changes from the vector table
    for (int i = 0; i < 8; i++) begin
      press(vecs[i].btn);
      u = cyc;
      chk($sformatf("vec%0d period", i), period, vecs[i].exp_period);
      chk($sformatf("vec%0d mode", i), 32'(mode), 32'(vecs[i].exp_mode));
      if (vecs[i].spacing > 0)
        pulse_window($sformatf("vec%0d pulses", i), u, vecs[i].spacing, vecs[i].len);
      release_all();
    end

    // Bounced FAST: glitches shorter than the debounce time, then a real press
    for (int g = 0; g < 2; g++) begin
      btn = 5'b00001;
      repeat (3) @(negedge clk);
      btn = '0;
      repeat (4) @(negedge clk);
    end
    chk("bounce no action", period, 32'd32);
    press(5'b00001);
    chk("bounce period", period, 32'd16);
    release_all();
    chk("bounce single action", period, 32'd16);

    // FAST held, SLOW pressed on top: second press ignored
    press(5'b00001);
    chk("hold fast period", period, 32'd8);
    press(5'b00010);
    repeat (5) @(negedge clk);
    chk("hold slow ignored", period, 32'd8);
    release_all();

    // FAST and CENTRE together in RUN: FAST wins
    press(5'b10001);
    chk("simul period", period, 32'd4);
    chk("simul mode", 32'(mode), 32'd0);
    release_all();

    // CENTRE pauses; no pulses while paused
    press(5'b10000);
    u = cyc;
    chk("pause mode", 32'(mode), 32'd1);
    chk("pause running", 32'(running), 32'd0);
    pulse_window("paused quiet", u, 0, 100);
    release_all();

    press(5'b00100);
    chk("paused slow period", period, 32'd8);
    chk("paused slow mode", 32'(mode), 32'd1);
    release_all();

    // Single step from PAUSED
    got_q.delete();
    press(5'b01000);
    u = cyc;
    chk("step mode", 32'(mode), 32'd2);
    chk("step pulse", 32'(step_en), 32'd1);
    repeat (20) @(negedge clk);
    chk("step back paused", 32'(mode), 32'd1);
    chk("step pulse count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("step pulse cyc", 32'(got_q[0]), 32'(u));
    release_all();

    // Resume
    press(5'b10000);
    u = cyc;
    chk("resume mode", 32'(mode), 32'd0);
    chk("resume running", 32'(running), 32'd1);
    pulse_window("resume pulses", u, 8, 20);
    release_all();

    // Reset mid-count with a pulse outstanding
    press(5'b00001);
    chk("pre-reset period", period, 32'd4);
    release_all();
    wait_step("pre-reset");
    reset = 1'b0;
    #1;
    chk("midreset step_en", 32'(step_en), 32'd0);
    chk("midreset mode",    32'(mode),    32'd0);
    chk("midreset period",  period,       32'd8);
    chk("midreset running", 32'(running), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    r = cyc;
    pulse_window("post-reset pulses", r, 8, 24);

    // max_tick at a step: pauses only in the stop-on-wrap build
    wait_step("wrap");
    max_tick = 1'b1;
    @(negedge clk);
    max_tick = 1'b0;
`ifdef LFSR_STOP_ON_WRAP_EN
    chk("wrap mode", 32'(mode), 32'd1);
    chk("wrap running", 32'(running), 32'd0);
`else
    chk("wrap mode", 32'(mode), 32'd0);
    chk("wrap running", 32'(running), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
